// File: rtl/restock_ctrl.sv
// rtl/restock_ctrl.sv - N-aisle restock controller: mode FSM, keypad amount entry, saturating commit
module restock_ctrl #(
  parameter int N_AISLE     = 4,
  parameter int CNT_W       = 8,
  parameter int MAX_QTY     = 99,
  parameter int CONFIRM_KEY = 14,
  parameter int CLEAR_KEY   = 15
) (
  input  logic                       clkout1,
  input  logic                       rst,
  input  logic                       mode_sold,
  input  logic                       mode_rst,
  input  logic                       mode_total,
  input  logic [N_AISLE-1:0]         aisle_sel,
  input  logic                       key_valid,
  input  logic [3:0]                 key_value,
  input  logic [N_AISLE*CNT_W-1:0]   in_num,
  output logic [N_AISLE*CNT_W-1:0]   num_out,
  output logic [6:0]                 pend,
  output logic [2:0]                 mode,
  output logic                       commit,
  output logic [N_AISLE-1:0]         sat,
  output logic                       sel_err
);

  typedef enum logic [2:0] {S_IDLE, S_SOLD, S_LOAD, S_EDIT, S_TOTAL} state_t;

  localparam logic [3:0]   CONF_K = 4'(CONFIRM_KEY);
  localparam logic [3:0]   CLR_K  = 4'(CLEAR_KEY);
  localparam logic [CNT_W:0] MAX_W = (CNT_W+1)'(MAX_QTY);

  state_t                     state, state_nxt;
  logic [N_AISLE*CNT_W-1:0]   num_nxt;
  logic [6:0]                 pend_nxt;
  logic [N_AISLE-1:0]         sat_nxt;
  logic [2:0]                 mode_nxt;
  logic                       commit_nxt, sel_err_nxt, changed;
  logic [CNT_W:0]             sum;
  logic [CNT_W-1:0]           cur, upd;

  always_ff @(posedge clkout1) begin
    if (!rst) begin
      state   <= S_IDLE;
      num_out <= '0;
      pend    <= '0;
      mode    <= '0;
      commit  <= 1'b0;
      sat     <= '0;
      sel_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      num_out <= num_nxt;
      pend    <= pend_nxt;
      mode    <= mode_nxt;
      commit  <= commit_nxt;
      sat     <= sat_nxt;
      sel_err <= sel_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    num_nxt     = num_out;
    pend_nxt    = pend;
    sat_nxt     = sat;
    mode_nxt    = 3'b000;
    commit_nxt  = 1'b0;
    sel_err_nxt = 1'b0;
    changed     = 1'b0;
    sum         = '0;
    cur         = '0;
    upd         = '0;

    case (state)
      S_LOAD: state_nxt = S_EDIT;
      S_EDIT: begin
        if (mode_sold)       state_nxt = S_SOLD;
        else if (mode_rst)   state_nxt = S_EDIT;
        else if (mode_total) state_nxt = S_TOTAL;
        else                 state_nxt = S_IDLE;
      end
      default: begin
        if (mode_sold)       state_nxt = S_SOLD;
        else if (mode_rst)   state_nxt = S_LOAD;
        else if (mode_total) state_nxt = S_TOTAL;
        else                 state_nxt = S_IDLE;
      end
    endcase

    case (state)
      S_SOLD:         mode_nxt = 3'b001;
      S_LOAD, S_EDIT: mode_nxt = 3'b010;
      S_TOTAL:        mode_nxt = 3'b100;
      default:        mode_nxt = 3'b000;
    endcase

    if (state == S_LOAD) begin
      num_nxt  = in_num;
      pend_nxt = '0;
      sat_nxt  = '0;
    end else if (state == S_EDIT) begin
      if (key_valid) begin
        if (key_value == CONF_K) begin
          if (aisle_sel == '0) begin
            sel_err_nxt = 1'b1;
          end else begin
            for (int i = 0; i < N_AISLE; i++) begin
              if (aisle_sel[i]) begin
                cur = num_out[i*CNT_W +: CNT_W];
                sum = {1'b0, cur} + (CNT_W+1)'(pend);
                if (sum > MAX_W) begin
                  upd        = MAX_W[CNT_W-1:0];
                  sat_nxt[i] = 1'b1;
                end else begin
                  upd = sum[CNT_W-1:0];
                end
                if (upd != cur) changed = 1'b1;
                num_nxt[i*CNT_W +: CNT_W] = upd;
              end
            end
            pend_nxt   = '0;
            commit_nxt = changed;
          end
        end else if (key_value == CLR_K) begin
          pend_nxt = '0;
        end else if (key_value <= 4'd9) begin
          // two-digit window: the old tens digit falls off
          pend_nxt = (pend % 7'd10) * 7'd10 + {3'b000, key_value};
        end
      end
      if (state_nxt != S_EDIT) pend_nxt = '0;
    end
  end

endmodule

// File: tb/tb_restock_ctrl.sv
// tb/tb_restock_ctrl.sv - directed self-checking bench for restock_ctrl
module tb_restock_ctrl;

  logic        clkout1 = 1'b0;
  logic        rst;
  logic        mode_sold, mode_rst, mode_total;
  logic [3:0]  aisle_sel;
  logic        key_valid;
  logic [3:0]  key_value;
  logic [31:0] in_num;
  logic [31:0] num_out;
  logic [6:0]  pend;
  logic [2:0]  mode;
  logic        commit;
  logic [3:0]  sat;
  logic        sel_err;

  int checks   = 0;
  int failures = 0;

  restock_ctrl dut (
    .clkout1   (clkout1),
    .rst       (rst),
    .mode_sold (mode_sold),
    .mode_rst  (mode_rst),
    .mode_total(mode_total),
    .aisle_sel (aisle_sel),
    .key_valid (key_valid),
    .key_value (key_value),
    .in_num    (in_num),
    .num_out   (num_out),
    .pend      (pend),
    .mode      (mode),
    .commit    (commit),
    .sat       (sat),
    .sel_err   (sel_err)
  );

  always #5 clkout1 = ~clkout1;

  task automatic tick();
    @(posedge clkout1);
    #1;
  endtask

  task automatic key(input logic [3:0] k);
    key_valid = 1'b1;
    key_value = k;
    tick();
    key_valid = 1'b0;
    key_value = 4'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  initial begin
    rst = 1'b0; mode_sold = 1'b0; mode_rst = 1'b0; mode_total = 1'b0;
    aisle_sel = 4'b0000; key_valid = 1'b0; key_value = 4'd0;
    in_num = {8'd40, 8'd30, 8'd20, 8'd10};
    tick(); tick();
    check("rst_num_out", num_out, 32'd0);
    check("rst_pend",    32'(pend), 32'd0);
    check("rst_mode",    32'(mode), 32'd0);
    check("rst_flags",   {26'd0, commit, sel_err, sat}, 32'd0);

    rst = 1'b1;
    tick();
    key(4'd5);
    check("idle_key_pend", 32'(pend), 32'd0);
    key(4'd14);
    check("idle_key_num",  num_out, 32'd0);
    check("idle_commit",   32'(commit), 32'd0);

    // restock entry: IDLE -> LOAD -> EDIT
    mode_rst = 1'b1;
    tick();
    tick();
    check("load_num_out", num_out, {8'd40, 8'd30, 8'd20, 8'd10});
    check("load_mode",    32'(mode), 32'd2);
    in_num = 32'hFFFF_FFFF;
    key(4'd1);
    key(4'd2);
    check("pend_12", 32'(pend), 32'd12);
    aisle_sel = 4'b0001;
    key(4'd14);
    check("t2_num_out", num_out, {8'd40, 8'd30, 8'd20, 8'd22});
    check("t2_commit",  32'(commit), 32'd1);
    check("t2_pend",    32'(pend), 32'd0);
    tick();
    check("t2_commit_once", 32'(commit), 32'd0);

    aisle_sel = 4'b0100;
    key(4'd6); key(4'd0); key(4'd14);
    check("t3_aisle2_90", num_out, {8'd40, 8'd90, 8'd20, 8'd22});
    key(4'd2); key(4'd5);
    check("t3_pend_25", 32'(pend), 32'd25);
    key(4'd14);
    check("t3_sat_num",    num_out, {8'd40, 8'd99, 8'd20, 8'd22});
    check("t3_sat_flag",   32'(sat), 32'h4);
    check("t3_sat_commit", 32'(commit), 32'd1);
    key(4'd5); key(4'd14);
    check("t3_full_num",    num_out, {8'd40, 8'd99, 8'd20, 8'd22});
    check("t3_full_commit", 32'(commit), 32'd0);
    check("t3_full_pend",   32'(pend), 32'd0);
    check("t3_sat_sticky",  32'(sat), 32'h4);

    key(4'd1); key(4'd2); key(4'd3);
    check("t4_window", 32'(pend), 32'd23);
    key(4'd15);
    check("t4_clear", 32'(pend), 32'd0);
    aisle_sel = 4'b0000;
    key(4'd7); key(4'd14);
    check("t4_sel_err",  32'(sel_err), 32'd1);
    check("t4_pend_kept", 32'(pend), 32'd7);
    check("t4_num_same", num_out, {8'd40, 8'd99, 8'd20, 8'd22});
    check("t4_no_commit", 32'(commit), 32'd0);
    tick();
    check("t4_sel_err_pulse", 32'(sel_err), 32'd0);

    key(4'd15);
    aisle_sel = 4'b1010;
    key(4'd5); key(4'd14);
    check("t5_multi", num_out, {8'd45, 8'd99, 8'd25, 8'd22});
    check("t5_commit", 32'(commit), 32'd1);

    aisle_sel = 4'b0000;
    key(4'd8);
    check("t6_pend_8", 32'(pend), 32'd8);
    mode_sold = 1'b1;
    tick();
    check("t6_pend_drop", 32'(pend), 32'd0);
    check("t6_num_keep",  num_out, {8'd45, 8'd99, 8'd25, 8'd22});
    tick();
    check("t6_mode_sold", 32'(mode), 32'd1);
    key(4'd3);
    check("t6_sold_key", 32'(pend), 32'd0);

    // back to restock: reload from in_num and clear sat
    mode_sold = 1'b0;
    in_num = {8'd4, 8'd3, 8'd2, 8'd1};
    tick(); tick();
    check("t6_reload", num_out, {8'd4, 8'd3, 8'd2, 8'd1});
    check("t6_sat_clr", 32'(sat), 32'd0);
    key(4'd9);
    check("t6_pend_9", 32'(pend), 32'd9);
    rst = 1'b0;
    tick();
    check("t6_rst_num",  num_out, 32'd0);
    check("t6_rst_pend", 32'(pend), 32'd0);
    check("t6_rst_mode", 32'(mode), 32'd0);

    rst = 1'b1; mode_rst = 1'b0; mode_total = 1'b1;
    tick(); tick();
    check("total_mode", 32'(mode), 32'd4);
    key(4'd6);
    check("total_key", 32'(pend), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
